// File: rtl/i2c_tgt_pkg.sv
// ---------------------------------------------------------------------------
// i2c_tgt_pkg
// Shared types and constants for the I2C target register block:
//   - i2c_state_t : protocol FSM states
//   - ACK         : bus level of an acknowledge bit
//   - BIT_CNT_W   : width of the per-byte bit counter (counts 0..8)
//   - addr_match  : compares the 7-bit address field of a received byte
// ---------------------------------------------------------------------------
package i2c_tgt_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ADDR     = 4'd1,
        ADDR_ACK = 4'd2,
        WR_PTR   = 4'd3,
        WR_DATA  = 4'd4,
        WR_ACK   = 4'd5,
        RD_DATA  = 4'd6,
        RD_ACK   = 4'd7,
        IGNORE   = 4'd8
    } i2c_state_t;

    localparam logic ACK = 1'b0;

    localparam int BIT_CNT_W = 4;

    localparam logic [BIT_CNT_W-1:0] CNT_ZERO = 4'd0;
    localparam logic [BIT_CNT_W-1:0] CNT_ONE  = 4'd1;
    localparam logic [BIT_CNT_W-1:0] CNT_LAST = 4'd7;
    localparam logic [BIT_CNT_W-1:0] CNT_BYTE = 4'd8;

    // Address byte is {addr[6:0], r/w}; only the upper seven bits identify the target.
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] tgt);
        return (addr_byte[7:1] == tgt);
    endfunction

endpackage

// File: rtl/i2c_tgt_sync.sv
// ---------------------------------------------------------------------------
// i2c_tgt_sync
// Conditions one open-drain pad input (SCL or SDA): 2-flop synchronizer,
// optional stability filter, and edge detection against the previous sample.
//
// Build option: I2C_TGT_FILTER_EN -- when defined, the synchronized level
// only changes after FILT_LEN consecutive samples at the new level, so
// shorter pulses are suppressed (adds FILT_LEN cycles of latency).
//
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset
//   din   in   raw pad input
//   level out  conditioned level
//   rise  out  level went 0 -> 1 this cycle
//   fall  out  level went 1 -> 0 this cycle
// ---------------------------------------------------------------------------
module i2c_tgt_sync #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_r;
    logic       filt_s;
    logic       prev_r;

    // Two-flop synchronizer; resets to the pulled-up idle bus level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], din};
        end
    end

`ifdef I2C_TGT_FILTER_EN
    localparam int CNT_W = $clog2(FILT_LEN + 1);

    logic [CNT_W-1:0] cnt_r;
    logic             filt_r;

    // Stability filter: counts consecutive samples that differ from the held
    // level and adopts the new level on the FILT_LEN-th one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_r <= 1'b1;
            cnt_r  <= {CNT_W{1'b0}};
        end else if (sync_r[1] == filt_r) begin
            cnt_r  <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_W'(FILT_LEN - 1)) begin
            filt_r <= sync_r[1];
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
        end
    end

    assign filt_s = filt_r;
`else
    // Without the filter FILT_LEN has no effect; the second term is constant 0.
    assign filt_s = sync_r[1] | (FILT_LEN < 0);
`endif

    // Previous conditioned sample for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= filt_s;
        end
    end

    assign level = filt_s;
    assign rise  = filt_s & ~prev_r;
    assign fall  = ~filt_s & prev_r;

endmodule

// File: rtl/i2c_target_regs.sv
// ---------------------------------------------------------------------------
// i2c_target_regs
// I2C target with NREG byte-wide registers. A write transaction sets the
// register pointer with its first data byte and writes the following bytes
// at auto-incrementing addresses; a read transaction returns registers from
// the current pointer. The pointer persists between transactions.
//
// Build option: I2C_TGT_FILTER_EN enables the input glitch filter in
// i2c_tgt_sync (FILT_LEN cycles deep).
//
// Ports:
//   HCLK     in   system clock (>= 16x SCL frequency)
//   HRESET   in   asynchronous active-high reset
//   scl_i    in   SCL pad input
//   sda_i    in   SDA pad input
//   sda_oe   out  1 = pull SDA low, 0 = release
//   data16   out  {reg[1], reg[0]}
//   wr_strb  out  one-cycle pulse per register write
//   wr_idx   out  index of the written register, valid with wr_strb
//   busy     out  high from an address match until STOP
// ---------------------------------------------------------------------------
module i2c_target_regs
    import i2c_tgt_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR = 7'h50,
    parameter int         NREG     = 4,
    parameter int         FILT_LEN = 3
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    scl_i,
    input  logic                    sda_i,
    output logic                    sda_oe,
    output logic [15:0]             data16,
    output logic                    wr_strb,
    output logic [$clog2(NREG)-1:0] wr_idx,
    output logic                    busy
);

    localparam int PW = $clog2(NREG);

    logic scl_lvl_s, scl_rise_s, scl_fall_s;
    logic sda_lvl_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;

    i2c_state_t           state_r, state_nxt;
    logic [BIT_CNT_W-1:0] cnt_r, cnt_nxt;
    logic [7:0]           shift_r, shift_nxt;
    logic [PW-1:0]        ptr_r, ptr_nxt;
    logic                 sda_oe_r, sda_oe_nxt;
    logic                 busy_r, busy_nxt;
    logic                 wr_en_s;
    logic                 wr_strb_r;
    logic [PW-1:0]        wr_idx_r;
    logic [7:0]           byte_s;
    logic [7:0]           rd_byte_s;
    logic [7:0]           regs_r [NREG];

    i2c_tgt_sync #(.FILT_LEN(FILT_LEN)) u_scl_sync (
        .clk   (HCLK),
        .rst   (HRESET),
        .din   (scl_i),
        .level (scl_lvl_s),
        .rise  (scl_rise_s),
        .fall  (scl_fall_s)
    );

    i2c_tgt_sync #(.FILT_LEN(FILT_LEN)) u_sda_sync (
        .clk   (HCLK),
        .rst   (HRESET),
        .din   (sda_i),
        .level (sda_lvl_s),
        .rise  (sda_rise_s),
        .fall  (sda_fall_s)
    );

    // SDA edges count as START/STOP only while SCL is stably high; an SCL
    // edge in the same sample makes it an ordinary data change.
    assign start_s   = sda_fall_s & scl_lvl_s & ~scl_rise_s;
    assign stop_s    = sda_rise_s & scl_lvl_s & ~scl_rise_s;

    assign byte_s    = {shift_r[6:0], sda_lvl_s};
    assign rd_byte_s = regs_r[ptr_r];

    // Next-state, shift, pointer and SDA-drive decisions.
    always_comb begin
        state_nxt  = state_r;
        cnt_nxt    = cnt_r;
        shift_nxt  = shift_r;
        ptr_nxt    = ptr_r;
        sda_oe_nxt = sda_oe_r;
        busy_nxt   = busy_r;
        wr_en_s    = 1'b0;

        if (stop_s) begin
            state_nxt  = IDLE;
            cnt_nxt    = CNT_ZERO;
            sda_oe_nxt = 1'b0;
            busy_nxt   = 1'b0;
        end else if (start_s) begin
            state_nxt  = ADDR;
            cnt_nxt    = CNT_ZERO;
            sda_oe_nxt = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_nxt = IDLE;
                end

                ADDR: begin
                    if (scl_rise_s) begin
                        shift_nxt = byte_s;
                        if (cnt_r == CNT_LAST) begin
                            cnt_nxt = CNT_ZERO;
                            if (addr_match(byte_s, TGT_ADDR)) begin
                                state_nxt = ADDR_ACK;
                                busy_nxt  = 1'b1;
                            end else begin
                                state_nxt = IGNORE;
                            end
                        end else begin
                            cnt_nxt = cnt_r + CNT_ONE;
                        end
                    end else begin
                        shift_nxt = shift_r;
                    end
                end

                // cnt_r = 0: first SCL fall starts the ACK; cnt_r = 1: the
                // fall after the 9th clock ends it. shift_r still holds the
                // address byte, so its LSB selects the read or write path.
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall_s) begin
                        if (cnt_r == CNT_ZERO) begin
                            sda_oe_nxt = ~ACK;
                            cnt_nxt    = CNT_ONE;
                        end else begin
                            cnt_nxt = CNT_ZERO;
                            if (state_r == WR_ACK) begin
                                state_nxt  = WR_DATA;
                                sda_oe_nxt = 1'b0;
                            end else if (shift_r[0]) begin
                                state_nxt  = RD_DATA;
                                shift_nxt  = rd_byte_s;
                                sda_oe_nxt = ~rd_byte_s[7];
                            end else begin
                                state_nxt  = WR_PTR;
                                sda_oe_nxt = 1'b0;
                            end
                        end
                    end else begin
                        cnt_nxt = cnt_r;
                    end
                end

                WR_PTR, WR_DATA: begin
                    if (scl_rise_s) begin
                        shift_nxt = byte_s;
                        if (cnt_r == CNT_LAST) begin
                            cnt_nxt   = CNT_ZERO;
                            state_nxt = WR_ACK;
                            if (state_r == WR_PTR) begin
                                ptr_nxt = byte_s[PW-1:0];
                            end else begin
                                wr_en_s = 1'b1;
                                ptr_nxt = ptr_r + PW'(1);
                            end
                        end else begin
                            cnt_nxt = cnt_r + CNT_ONE;
                        end
                    end else begin
                        shift_nxt = shift_r;
                    end
                end

                // The current bit is always shift_r[7]; each SCL fall moves to
                // the next one until the master has clocked all eight.
                RD_DATA: begin
                    if (scl_rise_s) begin
                        cnt_nxt = cnt_r + CNT_ONE;
                    end else if (scl_fall_s) begin
                        if (cnt_r == CNT_BYTE) begin
                            cnt_nxt    = CNT_ZERO;
                            state_nxt  = RD_ACK;
                            sda_oe_nxt = 1'b0;
                            ptr_nxt    = ptr_r + PW'(1);
                        end else begin
                            shift_nxt  = {shift_r[6:0], 1'b0};
                            sda_oe_nxt = ~shift_r[6];
                        end
                    end else begin
                        cnt_nxt = cnt_r;
                    end
                end

                RD_ACK: begin
                    if (scl_rise_s) begin
                        if (sda_lvl_s == ACK) begin
                            cnt_nxt = CNT_ONE;
                        end else begin
                            state_nxt = IGNORE;
                        end
                    end else if (scl_fall_s && (cnt_r == CNT_ONE)) begin
                        cnt_nxt    = CNT_ZERO;
                        state_nxt  = RD_DATA;
                        shift_nxt  = rd_byte_s;
                        sda_oe_nxt = ~rd_byte_s[7];
                    end else begin
                        cnt_nxt = cnt_r;
                    end
                end

                IGNORE: begin
                    state_nxt = IGNORE;
                end

                default: begin
                    state_nxt  = IDLE;
                    cnt_nxt    = CNT_ZERO;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // FSM state and protocol datapath registers.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            shift_r  <= 8'h00;
            ptr_r    <= {PW{1'b0}};
            sda_oe_r <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            cnt_r    <= cnt_nxt;
            shift_r  <= shift_nxt;
            ptr_r    <= ptr_nxt;
            sda_oe_r <= sda_oe_nxt;
            busy_r   <= busy_nxt;
        end
    end

    // Register file and write strobe; byte_s is the completed data byte.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= 8'h00;
            end
            wr_strb_r <= 1'b0;
            wr_idx_r  <= {PW{1'b0}};
        end else begin
            wr_strb_r <= wr_en_s;
            if (wr_en_s) begin
                regs_r[ptr_r] <= byte_s;
                wr_idx_r      <= ptr_r;
            end else begin
                wr_idx_r      <= wr_idx_r;
            end
        end
    end

    assign sda_oe  = sda_oe_r;
    assign busy    = busy_r;
    assign wr_strb = wr_strb_r;
    assign wr_idx  = wr_idx_r;
    assign data16  = {regs_r[1], regs_r[0]};

endmodule

// File: tb/tb_i2c_target_regs.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regs
// Directed bench: a bit-banged I2C master drives scl/sda through a wired-AND
// pad model, and each observed value is compared against a hand-computed
// expectation through chk().
// ---------------------------------------------------------------------------
module tb_i2c_target_regs;

    logic        HCLK;
    logic        HRESET;
    logic        scl_m;
    logic        sda_m;
    logic        sda_line;
    logic        sda_oe;
    logic [15:0] data16;
    logic        wr_strb;
    logic [1:0]  wr_idx;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Monitor state (written only by the monitor process).
    int         strb_cnt = 0;
    int         strb_run = 0;
    int         strb_max = 0;
    int         oe_cnt   = 0;
    int         busy_cnt = 0;
    logic [1:0] idx_log[$];

    assign sda_line = sda_m & ~sda_oe;

    i2c_target_regs #(
        .TGT_ADDR (7'h50),
        .NREG     (4),
        .FILT_LEN (3)
    ) dut (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .scl_i   (scl_m),
        .sda_i   (sda_line),
        .sda_oe  (sda_oe),
        .data16  (data16),
        .wr_strb (wr_strb),
        .wr_idx  (wr_idx),
        .busy    (busy)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Observe strobes, SDA drive and busy once per cycle.
    always @(negedge HCLK) begin
        if (wr_strb) begin
            strb_cnt <= strb_cnt + 1;
            strb_run <= strb_run + 1;
            if (strb_run + 1 > strb_max) strb_max <= strb_run + 1;
            idx_log.push_back(wr_idx);
        end else begin
            strb_run <= 0;
        end
        if (sda_oe) oe_cnt <= oe_cnt + 1;
        if (busy)   busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic q_wait();
        repeat (5) @(negedge HCLK);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; scl_m = 1'b1; q_wait();
        sda_m = 1'b0; q_wait();
        scl_m = 1'b0; q_wait();
    endtask

    task automatic bus_rstart();
        q_wait(); sda_m = 1'b1;
        q_wait(); scl_m = 1'b1;
        q_wait(); sda_m = 1'b0;
        q_wait(); scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        q_wait(); sda_m = 1'b0;
        q_wait(); scl_m = 1'b1;
        q_wait(); sda_m = 1'b1;
        q_wait();
    endtask

    task automatic send_bit(input logic b);
        q_wait(); sda_m = b;
        q_wait(); scl_m = 1'b1;
        q_wait(); q_wait(); scl_m = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        q_wait(); sda_m = 1'b1;
        q_wait(); scl_m = 1'b1;
        q_wait(); b = sda_line;
        q_wait(); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(ack);
    endtask

    // Watchdog: the stimulus is fixed-length, so this only trips on a hang.
    initial begin
        #600000;
        $display("FAIL watchdog: time %0t, required finish before 600000", $time);
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] rd;
        int         base;
        int         oe0;
        int         busy0;

        HRESET = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        repeat (4) @(negedge HCLK);
        HRESET = 1'b0;
        repeat (4) @(negedge HCLK);

        // Reset state
        chk("rst_sda_oe",  sda_oe,  0);
        chk("rst_busy",    busy,    0);
        chk("rst_wr_strb", wr_strb, 0);
        chk("rst_wr_idx",  wr_idx,  0);
        chk("rst_data16",  data16,  0);

        // Write 0x00, 0x45, 0x00 to address 0x50
        base = strb_cnt;
        bus_start();
        write_byte(8'hA0, ack); chk("t2_addr_ack", ack, 0);
        chk("t2_busy_hi", busy, 1);
        write_byte(8'h00, ack); chk("t2_ptr_ack", ack, 0);
        write_byte(8'h45, ack); chk("t2_d0_ack", ack, 0);
        write_byte(8'h00, ack); chk("t2_d1_ack", ack, 0);
        chk("t2_busy_pre_stop", busy, 1);
        bus_stop();
        chk("t2_busy_lo", busy, 0);
        chk("t2_strb_cnt", strb_cnt - base, 2);
        chk("t2_idx0", idx_log[base], 0);
        chk("t2_idx1", idx_log[base + 1], 1);
        chk("t2_data16", data16, 16'd69);

        // Address 0x51: no match, target stays silent
        base = strb_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
        bus_start();
        write_byte(8'hA2, ack); chk("t3_addr_nack", ack, 1);
        write_byte(8'h12, ack); chk("t3_data_nack", ack, 1);
        bus_stop();
        chk("t3_no_oe",   oe_cnt - oe0, 0);
        chk("t3_no_strb", strb_cnt - base, 0);
        chk("t3_no_busy", busy_cnt - busy0, 0);
        chk("t3_data16",  data16, 16'd69);

        // Pointer 3, then 0xAA, 0xBB: wraps to register 0
        base = strb_cnt;
        bus_start();
        write_byte(8'hA0, ack); chk("t4_addr_ack", ack, 0);
        write_byte(8'h03, ack); chk("t4_ptr_ack", ack, 0);
        write_byte(8'hAA, ack); chk("t4_d0_ack", ack, 0);
        write_byte(8'hBB, ack); chk("t4_d1_ack", ack, 0);
        bus_stop();
        chk("t4_idx0", idx_log[base], 3);
        chk("t4_idx1", idx_log[base + 1], 0);
        chk("t4_data16", data16, 16'h00BB);

        // Fill reg1/reg2, then pointer-only write, repeated START, read 2
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h01, ack);
        write_byte(8'h5A, ack);
        write_byte(8'hC3, ack); chk("t5_fill_ack", ack, 0);
        bus_stop();
        chk("t5_data16", data16, 16'h5ABB);
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h01, ack); chk("t5_ptr_ack", ack, 0);
        bus_rstart();
        write_byte(8'hA1, ack); chk("t5_rd_addr_ack", ack, 0);
        read_byte(rd, 1'b0);    chk("t5_rd0", rd, 8'h5A);
        read_byte(rd, 1'b1);    chk("t5_rd1", rd, 8'hC3);
        q_wait();
        chk("t5_release_after_nack", sda_oe, 0);
        chk("t5_busy_until_stop", busy, 1);
        bus_stop();
        chk("t5_busy_lo", busy, 0);

        // Pointer byte 0x07 is taken mod 4 -> reg3, then read wraps to reg0
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h07, ack);
        bus_rstart();
        write_byte(8'hA1, ack);
        read_byte(rd, 1'b0); chk("t5_rd_reg3", rd, 8'hAA);
        read_byte(rd, 1'b1); chk("t5_rd_wrap", rd, 8'hBB);
        bus_stop();

        // Reset while the target is driving the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hA0 >> i));
        q_wait();
        chk("t6_ack_driven", sda_oe, 1);
        HRESET = 1'b1;
        #1;
        chk("t6_async_release", sda_oe, 0);
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        chk("t6_busy_after_rst", busy, 0);
        chk("t6_data16_cleared", data16, 0);
        bus_stop();

        // Reset during the 5th bit of a data byte
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h00, ack);
        write_byte(8'h45, ack);
        chk("t6b_data16_pre", data16, 16'h0045);
        for (int i = 7; i >= 4; i--) send_bit(1'(8'h3C >> i));
        q_wait(); sda_m = 1'b1;
        q_wait(); scl_m = 1'b1;
        q_wait();
        HRESET = 1'b1;
        #1;
        chk("t6b_sda_oe", sda_oe, 0);
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        chk("t6b_regs_cleared", data16, 0);
        chk("t6b_busy", busy, 0);
        q_wait(); scl_m = 1'b0;
        bus_stop();

        // Next full transaction works after reset
        base = strb_cnt;
        bus_start();
        write_byte(8'hA0, ack); chk("t6c_addr_ack", ack, 0);
        write_byte(8'h00, ack); chk("t6c_ptr_ack", ack, 0);
        write_byte(8'h45, ack); chk("t6c_d0_ack", ack, 0);
        write_byte(8'h00, ack); chk("t6c_d1_ack", ack, 0);
        bus_stop();
        chk("t6c_strb_cnt", strb_cnt - base, 2);
        chk("t6c_data16", data16, 16'd69);

`ifdef I2C_TGT_FILTER_EN
        // 1-cycle SDA low glitch with SCL high must not count as START
        oe0 = oe_cnt;
        sda_m = 1'b0;
        @(negedge HCLK);
        sda_m = 1'b1;
        q_wait();
        q_wait(); scl_m = 1'b0;
        write_byte(8'hA0, ack);
        chk("t7_glitch_no_start", ack, 1);
        chk("t7_glitch_no_oe", oe_cnt - oe0, 0);
        chk("t7_glitch_busy", busy, 0);
        bus_stop();
`endif

        chk("strb_width", strb_max, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
